// File: rtl/reg_bank_if.sv
// reg_bank_if: bus bundle for reg_bank (write port, two read ports, clear request, status)
//   master: drives clr_req, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB; samples datA_out, datB_out, busy, wr_drop
//   slave:  the register bank side of the same signals
interface reg_bank_if #(parameter int DW = 8, parameter int AW = 3);
  logic          clr_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic [DW-1:0] datA_out;
  logic [DW-1:0] datB_out;
  logic          busy;
  logic          wr_drop;
  modport master (
    output clr_req, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
    input  datA_out, datB_out, busy, wr_drop
  );
  modport slave (
    input  clr_req, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
    output datA_out, datB_out, busy, wr_drop
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: 2**AW x DW register file, two combinational read ports, one write port,
//   and a sequential clear sweep (one register per cycle) requested by clr_req.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (clears storage, aborts a sweep)
//   bus   - reg_bank_if.slave: clr_req, wr_en, wr_addr, dat_in, rd_addrA/B in;
//           datA_out/datB_out, busy (sweep in progress), wr_drop (rejected-write pulse) out
//   Optional: define REG_BANK_BYPASS_EN to forward an accepted write onto matching read ports.
module reg_bank #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic         clk,
  input logic         reset,
  reg_bank_if.slave   bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        state, next;
  logic [AW-1:0] ptr;
  logic [DW-1:0] regs [DEPTH];
  logic          drop;
  logic          acc;
  assign acc = bus.wr_en && state == IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  always_comb begin
    next = state;
    next = (state == IDLE) ? (bus.clr_req ? CLEAR : IDLE) : (ptr == LAST ? IDLE : CLEAR);
  end
  // ptr wraps from LAST back to 0 on the final sweep cycle, so it rests at 0 in IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      ptr  <= '0;
      drop <= 1'b0;
    end else begin
      drop <= bus.wr_en && state == CLEAR;
      if (state == CLEAR) begin
        regs[ptr] <= '0;
        ptr       <= ptr + 1'b1;
      end else if (acc) begin
        regs[bus.wr_addr] <= bus.dat_in;
      end
    end
  assign bus.busy    = state == CLEAR;
  assign bus.wr_drop = drop;
`ifdef REG_BANK_BYPASS_EN
  assign bus.datA_out = (acc && bus.wr_addr == bus.rd_addrA) ? bus.dat_in : regs[bus.rd_addrA];
  assign bus.datB_out = (acc && bus.wr_addr == bus.rd_addrB) ? bus.dat_in : regs[bus.rd_addrB];
`else
  assign bus.datA_out = regs[bus.rd_addrA];
  assign bus.datB_out = regs[bus.rd_addrB];
`endif
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank (DW=8, AW=3)
module tb_reg_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  reg_bank_if #(.DW(8), .AW(3)) bus ();
  reg_bank #(.DW(8), .AW(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.dat_in = d;
    step();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    bus.rd_addrA = a;
    bus.rd_addrB = b;
    #1;
  endtask
  task automatic clr_pulse();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("sweep_ends", {7'd0, bus.busy}, 8'h00);
  endtask
  initial begin
    bus.clr_req = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.dat_in = '0;
    bus.rd_addrA = 3'd0;
    bus.rd_addrB = 3'd7;
    #2;
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_drop", {7'd0, bus.wr_drop}, 8'h00);
    chk("rst_datA", bus.datA_out, 8'h00);
    chk("rst_datB", bus.datB_out, 8'h00);
    #1 reset = 1'b0;
    step();
    // basic write/read
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h5A);
    rd(3'd3, 3'd7);
    chk("rd_a3", bus.datA_out, 8'hA5);
    chk("rd_b7", bus.datB_out, 8'h5A);
    rd(3'd7, 3'd7);
    chk("same_a", bus.datA_out, 8'h5A);
    chk("same_b", bus.datB_out, 8'h5A);
    // fill then full sweep; a clr_req mid-sweep must not extend it
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h11 * (i + 1)));
    rd(3'd2, 3'd6);
    chk("fill_a2", bus.datA_out, 8'h33);
    chk("fill_b6", bus.datB_out, 8'h77);
    clr_pulse();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy_c%0d", i), {7'd0, bus.busy}, 8'h01);
      if (i == 4) begin
        rd(3'd3, 3'd5);
        chk("sweep_a3", bus.datA_out, 8'h00);
        chk("sweep_b5", bus.datB_out, 8'h66);
      end
      bus.clr_req = (i == 2);
      step();
    end
    bus.clr_req = 1'b0;
    chk("busy_fall", {7'd0, bus.busy}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk($sformatf("clr_a%0d", i), bus.datA_out, 8'h00);
    end
    // dropped write during sweep
    wr(3'd2, 8'h22);
    clr_pulse();
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd2;
    bus.dat_in = 8'hFF;
    rd(3'd2, 3'd2);
    chk("drop_nofwd", bus.datA_out, 8'h22);
    chk("drop_pre", {7'd0, bus.wr_drop}, 8'h00);
    step();
    bus.wr_en = 1'b0;
    #1;
    chk("drop_pulse", {7'd0, bus.wr_drop}, 8'h01);
    step();
    chk("drop_end", {7'd0, bus.wr_drop}, 8'h00);
    wait_idle();
    rd(3'd2, 3'd2);
    chk("drop_a2", bus.datA_out, 8'h00);
    // reset mid-sweep
    wr(3'd6, 8'h77);
    clr_pulse();
    step();
    step();
    step();
    reset = 1'b1;
    rd(3'd6, 3'd1);
    chk("rst_mid_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_mid_a6", bus.datA_out, 8'h00);
    #1 reset = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd1;
    bus.dat_in = 8'h42;
    step();
    bus.wr_en = 1'b0;
    #1;
    chk("post_rst_b1", bus.datB_out, 8'h42);
    chk("post_rst_drop", {7'd0, bus.wr_drop}, 8'h00);
    // write-through behaviour
    wr(3'd4, 8'h10);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd4;
    bus.dat_in = 8'h3C;
    rd(3'd4, 3'd0);
`ifdef REG_BANK_BYPASS_EN
    chk("bypass_pre", bus.datA_out, 8'h3C);
`else
    chk("bypass_pre", bus.datA_out, 8'h10);
`endif
    step();
    bus.wr_en = 1'b0;
    #1;
    chk("bypass_post", bus.datA_out, 8'h3C);
    // write and clear request together
    wr(3'd0, 8'h55);
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0;
    bus.dat_in = 8'h99;
    bus.clr_req = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.clr_req = 1'b0;
    rd(3'd0, 3'd4);
    chk("both_busy", {7'd0, bus.busy}, 8'h01);
    chk("both_a0", bus.datA_out, 8'h99);
    chk("both_b4", bus.datB_out, 8'h3C);
    step();
    #1;
    chk("both_drop", {7'd0, bus.wr_drop}, 8'h00);
    chk("both_a0_clr", bus.datA_out, 8'h00);
    chk("both_b4_old", bus.datB_out, 8'h3C);
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
